// File: rtl/npc_bus_pkg.sv
// npc_bus_pkg: shared definitions for the npc core memory-side buses.
//   state_t      : arbiter FSM states (IDLE, GRANT, WAIT)
//   OWN_IFU/LSU  : owner encoding; also the bit index of each requester
//                  in the two-bit request/grant vectors
//   RESP_*       : slave response codes
package npc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0] : request vector, bit 0 = IFU, bit 1 = LSU
//   last     : requester granted last (OWN_IFU / OWN_LSU)
//   gnt[1:0] : one-hot grant, or zero when nothing is requested
module rr_arb2
    import npc_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie, the requester that was not served last wins.
        if (req == 2'b11) begin
            gnt = (last == OWN_IFU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory slave port between the IFU and the LSU.
// One transaction is in flight at a time: IDLE picks a requester and
// latches its request, GRANT presents it to the slave, WAIT passes the
// slave response straight through to the owner.
//   clk, rst            : clock, synchronous active-high reset
//   ifu_req_* / ifu_*   : IFU request (addr) and response (rdata, resp)
//   lsu_req_* / lsu_*   : LSU request (addr, wen, wdata, wmask) and response
//   mem_req_* / mem_*   : latched request to the slave
//   mem_rsp_* / mem_*   : slave response (rdata, resp)
module mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    output logic [DW-1:0]   ifu_rdata,
    output logic [1:0]      ifu_resp,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   lsu_rdata,
    output logic [1:0]      lsu_resp,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [DW-1:0]   mem_rdata,
    input  logic [1:0]      mem_resp
);

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic [1:0]      gnt;

    logic            in_idle;
    logic            in_grant;
    logic            in_wait;
    logic            owner_rsp_ready;
    logic            ifu_sel;
    logic            lsu_sel;

    rr_arb2 u_pick (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_grant),
        .gnt  (gnt)
    );

    // Gating with rst keeps every handshake output low in the reset cycle,
    // even while the state register still holds a pre-reset value.
    assign in_idle  = (state == IDLE)  && !rst;
    assign in_grant = (state == GRANT) && !rst;
    assign in_wait  = (state == WAIT)  && !rst;

    // Depends only on state and requester valids, never on mem_req_ready.
    assign ifu_req_ready = in_idle && gnt[OWN_IFU];
    assign lsu_req_ready = in_idle && gnt[OWN_LSU];

    assign mem_req_valid = in_grant;

    assign owner_rsp_ready = (owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    assign mem_rsp_ready   = in_wait && owner_rsp_ready;

    assign ifu_sel = in_wait && (owner == OWN_IFU);
    assign lsu_sel = in_wait && (owner == OWN_LSU);

    assign ifu_rsp_valid = ifu_sel && mem_rsp_valid;
    assign lsu_rsp_valid = lsu_sel && mem_rsp_valid;
    assign ifu_rdata     = ifu_sel ? mem_rdata : '0;
    assign ifu_resp      = ifu_sel ? mem_resp  : RESP_OKAY;
    assign lsu_rdata     = lsu_sel ? mem_rdata : '0;
    assign lsu_resp      = lsu_sel ? mem_resp  : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A nonzero grant implies the winner's valid is high,
                    // so the grant itself is the request handshake.
                    if (gnt[OWN_IFU]) begin
                        mem_addr  <= ifu_addr;
                        mem_wen   <= 1'b0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        owner     <= OWN_IFU;
                        state     <= GRANT;
                    end else if (gnt[OWN_LSU]) begin
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        owner     <= OWN_LSU;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid && owner_rsp_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0]   ifu_addr;
    logic [DW-1:0]   ifu_rdata;
    logic [1:0]      ifu_resp;
    logic            lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
    logic [AW-1:0]   lsu_addr;
    logic            lsu_wen;
    logic [DW-1:0]   lsu_wdata, lsu_rdata;
    logic [DW/8-1:0] lsu_wmask;
    logic [1:0]      lsu_resp;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wmask;
    logic [1:0]      mem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp(ifu_resp),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp(lsu_resp),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one more unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = '0; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = '0; mem_resp = 2'b00;

        // ---- reset: every handshake output low even with all inputs high
        tick(); tick(); settle();
        chk("rst_ifu_req_ready", ifu_req_ready, 0);
        chk("rst_lsu_req_ready", lsu_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
        chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        rst = 1'b0;
        tick();

        // ---- IFU-only read of 0x80000000
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        settle();
        chk("t1_ifu_req_ready", ifu_req_ready, 1);
        chk("t1_lsu_req_ready", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678;
        settle();
        chk("t1_mem_req_valid", mem_req_valid, 1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", mem_wen, 0);
        chk("t1_lsu_rsp_valid_g", lsu_rsp_valid, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413; mem_resp = 2'b00;
        settle();
        chk("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_ifu_resp", ifu_resp, 2'b00);
        chk("t1_lsu_rsp_valid_w", lsu_rsp_valid, 0);
        chk("t1_lsu_rdata", lsu_rdata, 0);
        chk("t1_mem_rsp_ready", mem_rsp_ready, 1);
        tick();
        mem_rsp_valid = 1'b0;

        // ---- four ties with both valids held: LSU, IFU, LSU, IFU
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000;
        lsu_wen = 1'b1; lsu_wdata = 32'hA5A5_0001; lsu_wmask = 4'h3;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            settle();
            chk($sformatf("t2_%0d_lsu_gnt", i), lsu_req_ready, exp_lsu);
            chk($sformatf("t2_%0d_ifu_gnt", i), ifu_req_ready, !exp_lsu);
            tick(); settle();
            chk($sformatf("t2_%0d_mem_addr", i), mem_addr,
                exp_lsu ? 32'h0000_2000 : 32'h0000_1000);
            chk($sformatf("t2_%0d_mem_wen", i), mem_wen, exp_lsu);
            chk($sformatf("t2_%0d_mem_wmask", i), mem_wmask, exp_lsu ? 4'h3 : 4'h0);
            chk($sformatf("t2_%0d_nogrant_g", i), {ifu_req_ready, lsu_req_ready}, 0);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0100 + i; mem_resp = 2'b00;
            settle();
            chk($sformatf("t2_%0d_nogrant_w", i), {ifu_req_ready, lsu_req_ready}, 0);
            chk($sformatf("t2_%0d_rsp_valid", i), {lsu_rsp_valid, ifu_rsp_valid},
                exp_lsu ? 2'b10 : 2'b01);
            tick();
            mem_rsp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // ---- LSU write held off by the slave for 5 cycles
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        settle();
        chk("t3_lsu_req_ready", lsu_req_ready, 1);
        tick();
        // Change the source fields to confirm the slave sees latched copies.
        lsu_addr = 32'h0BAD_0BAD; lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_wen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("t3_%0d_mem_req_valid", c), mem_req_valid, 1);
            chk($sformatf("t3_%0d_fields", c), {mem_addr, mem_wdata},
                {32'h8000_1000, 32'hDEAD_BEEF});
            chk($sformatf("t3_%0d_wen_wmask", c), {mem_wen, mem_wmask}, {1'b1, 4'hF});
            chk($sformatf("t3_%0d_lsu_req_ready", c), lsu_req_ready, 0);
            tick();
        end
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;

        // ---- response backpressure from the LSU for 3 cycles
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_5555; mem_resp = 2'b00;
        lsu_rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("t4_%0d_mem_rsp_ready", c), mem_rsp_ready, 0);
            chk($sformatf("t4_%0d_lsu_rsp_valid", c), lsu_rsp_valid, 1);
            tick();
        end
        lsu_rsp_ready = 1'b1;
        settle();
        chk("t4_mem_rsp_ready", mem_rsp_ready, 1);
        chk("t4_lsu_rdata", lsu_rdata, 32'h0000_5555);
        tick();
        mem_rsp_valid = 1'b0;

        // ---- IDLE the cycle after the handshake; IFU fetch gets DECERR
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0000;
        settle();
        chk("t5_ifu_req_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0; mem_resp = 2'b11;
        settle();
        chk("t5_ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("t5_ifu_resp", ifu_resp, 2'b11);
        chk("t5_lsu_resp", lsu_resp, 2'b00);
        tick();
        mem_rsp_valid = 1'b0; mem_resp = 2'b00;

        // Next request (LSU read) goes through normally.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        settle();
        chk("t5_next_lsu_req_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0077;
        settle();
        chk("t5_next_lsu_rdata", lsu_rdata, 32'h0000_0077);
        tick();
        mem_rsp_valid = 1'b0;

        // ---- rst in WAIT: LSU was served last, so without reset a tie
        // would go to the IFU; after reset it must go to the LSU.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
        settle();
        chk("t6_lsu_req_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1; mem_rsp_valid = 1'b1;
        settle();
        chk("t6_rstcyc_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("t6_rstcyc_mem_rsp_ready", mem_rsp_ready, 0);
        tick();
        rst = 1'b0; mem_rsp_valid = 1'b0;
        settle();
        chk("t6_post_handshakes",
            {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready,
             ifu_rsp_valid, lsu_rsp_valid}, 6'b0);
        chk("t6_post_mem_addr", mem_addr, 0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        settle();
        chk("t6_tie_gnt", {lsu_req_ready, ifu_req_ready}, 2'b10);
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        settle();
        chk("t6_tie_mem_addr", mem_addr, 32'h8000_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single memory slave port between instruction fetch (IFU) and load/store (LSU) in the npc core.
- Accepts one request at a time and forwards it to the slave.
- Routes the slave's response back to the owner, then releases the port.
- Uses the same valid/ready convention as the inter-stage buses.
- Sits between the IFU/LSU bus ports and the memory or SoC bridge.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; the write mask is DW/8 bits

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  AW  fetch address
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DW  fetched word
- ifu_resp  out  2  response code
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  AW  access address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  byte enables
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake
- lsu_rdata  out  DW  load data
- lsu_resp  out  2  response code
- mem_req_valid / mem_req_ready  out / in  1  slave request handshake
- mem_addr  out  AW  latched address
- mem_wen  out  1  latched write flag
- mem_wdata  out  DW  latched store data
- mem_wmask  out  DW/8  latched byte enables
- mem_rsp_valid / mem_rsp_ready  in / out  1  slave response handshake
- mem_rdata  in  DW  slave read data
- mem_resp  in  2  slave response code; 00 OKAY, 10 SLVERR, 11 DECERR

## Operation
States and transitions:
- IDLE → GRANT when either request is valid.
- GRANT → WAIT when mem_req_ready = 1.
- WAIT → IDLE when mem_rsp_valid && owner rsp_ready.

IDLE (arbitration):
- Combinational pick between the two requesters:
  - only one valid: that one wins;
  - both valid: round-robin, the winner is the requester not granted last (last_grant).
- The winner's req_ready = 1 in the same cycle; the loser's req_ready = 0.
- On the handshake: latch addr, wen, wdata and wmask into registers, set owner, go to GRANT.
- An IFU grant latches wen = 0 and wmask = 0.

GRANT:
- mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
- Then go to WAIT.

WAIT:
- mem_rsp_ready = owner's rsp_ready.
- Owner's rsp_valid = mem_rsp_valid.
- Owner's rdata/resp = mem_rdata/mem_resp, passed through combinationally.
- On the response handshake: last_grant ← owner, go to IDLE.

Always-inactive outputs:
- The non-owner's rsp_valid is 0.
- Both req_ready are 0 outside IDLE.
- mem_rsp_ready is 0 outside WAIT; a slave response arriving then is not accepted.
- Non-owner rdata/resp are driven 0.

Reset (rst = 1):
- state ← IDLE, last_grant ← IFU (a tie right after reset goes to the LSU).
- All latched fields ← 0.
- Every valid/ready output is 0 in the reset cycle.
- Reset mid-transaction abandons it silently; the slave is reset by the same rst.

## Timing
- Request accepted in cycle N → mem_req_valid asserted in N+1 at the earliest.
- Response is zero-latency pass-through: a requester sees rsp_valid in the same cycle as mem_rsp_valid.
- After the response handshake in cycle M, the arbiter is in IDLE at M+1 and can accept the next request in M+1.
- Minimum round trip, from req handshake to rsp handshake, with an always-ready slave returning its response the cycle after mem_req accept: 3 cycles.
- At most one outstanding transaction; no pipelining of requests.
- Requester valid need not be held while the arbiter is busy; arbitration sees only the current-cycle valids in IDLE.
- No combinational path from mem_req_ready to any req_ready.

## Structure
- Shared package npc_bus_pkg:
  - state enum IDLE/GRANT/WAIT;
  - owner encoding OWN_IFU = 0, OWN_LSU = 1;
  - resp constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- One sub-module, rr_arb2: a combinational two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] (one-hot or zero).
- FSM, latches and response mux stay in mem_arbiter.

## Test plan
- IFU-only read: ifu_addr = 0x80000000, slave returns 0x00000413/OKAY → ifu_rsp_valid with ifu_rdata = 0x00000413, ifu_resp = 00, lsu_rsp_valid = 0 throughout, mem_wen = 0.
- Simultaneous requests for 4 consecutive transactions, both valids held high: LSU, IFU, LSU, IFU → grant order LSU, IFU, LSU, IFU; no grant is ever given outside IDLE.
- LSU write with mem_req_ready held low for 5 cycles: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF → mem_* fields stable through all 5 cycles; lsu_req_ready stays 0 after the accept cycle.
- Response backpressure: mem_rsp_valid = 1 while lsu_rsp_ready = 0 for 3 cycles → mem_rsp_ready = 0 for those cycles; handshake completes on the cycle lsu_rsp_ready rises; IDLE on the next cycle.
- Error passthrough: slave returns DECERR to an IFU fetch of 0x00000000 → ifu_resp = 11; the next request is accepted normally.
- rst pulsed while in WAIT → the following cycle shows IDLE with all valid/ready outputs 0; a later tie is granted to the LSU.
